// File: rtl/fetch_unit_pkg.sv
// Shared front-end definitions: instruction size, fetch FSM states and default boot PC.
package fetch_unit_pkg;

   // Every LEGv8 instruction is one 32-bit word.
   localparam int unsigned INST_BYTES = 4;

   // Boot address used when the top-level RESET_PC parameter is left at its default.
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

   // StFlush means responses to fetches issued before a redirect are still in flight and must
   // be thrown away as they arrive.
   typedef enum logic [0:0] {
      StFetch,
      StFlush
   } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: small synchronous FIFO of {PC, instruction} pairs sitting between the
// instruction-memory response path and decode. Flush wins over a same-cycle push or pop.
module fetch_buf #(
   parameter int unsigned  DEPTH = 2,
   parameter int unsigned  WIDTH = 96,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             resetl_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] head_o,
   output logic [CW-1:0]    occ_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q;
   logic [PW-1:0]    wr_q;
   logic [CW-1:0]    occ_q;
   logic             do_pop;
   logic             do_push;

   // Pointer increment that wraps at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      if (ptr == PW'(DEPTH - 1)) begin
         return '0;
      end
      return ptr + PW'(1);
   endfunction

   // A pop frees a slot, so a push into a full buffer is fine in the same cycle.
   assign do_pop  = pop_i && (occ_q != '0);
   assign do_push = push_i && ((occ_q < CW'(DEPTH)) || do_pop);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (!resetl_i || flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         occ_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= ptr_inc(wr_q);
         end
         if (do_pop) begin
            rd_q <= ptr_inc(rd_q);
         end
         occ_q <= occ_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: entries are only visible while counted in occ_q.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         mem_q[wr_q] <= push_data_i;
      end
   end

   // No bypass: a pushed word shows up at the head the cycle after it arrives.
   assign valid_o = (occ_q != '0);
   assign head_o  = valid_o ? mem_q[rd_q] : '0;
   assign occ_o   = occ_q;

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch front end: owns the fetch PC, issues in-order instruction-memory reads under a
// credit limit, buffers returned words with their PC for decode, and restarts on redirect while
// discarding responses to fetches that were already in flight.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 64,
   parameter int unsigned       INST_W    = 32,
   parameter int unsigned       BUF_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              CLK,
   input  logic              resetl,
   output logic              IMemReq,
   output logic [ADDR_W-1:0] IMemAddr,
   input  logic              IMemReady,
   input  logic              IMemRspValid,
   input  logic [INST_W-1:0] IMemRspData,
   output logic              InstValid,
   output logic [INST_W-1:0] Inst,
   output logic [ADDR_W-1:0] InstPC,
   input  logic              InstReady,
   input  logic              Redirect,
   input  logic [ADDR_W-1:0] RedirectPC
);

   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned BW = ADDR_W + INST_W;

   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] rsp_pc_q;
   logic [CW-1:0]     out_cnt_q;
   logic [CW-1:0]     out_cnt_d;
   logic [CW-1:0]     drop_cnt_q;
   logic [CW-1:0]     drop_cnt_d;
   fetch_state_e      state_q;

   logic [CW-1:0]     occ;
   logic [CW:0]       inflight;
   logic              credit;
   logic              req_fire;
   logic              rsp_ok;
   logic              rsp_drop;
   logic              rsp_keep;
   logic [ADDR_W-1:0] redirect_pc;
   logic [BW-1:0]     buf_head;
   logic              buf_valid;
   logic              unused_rpc;

   // Low address bits of the target are ignored; fetches are always word aligned.
   assign redirect_pc = {RedirectPC[ADDR_W-1:2], 2'b00};
   assign unused_rpc  = ^RedirectPC[1:0];

   // Outstanding plus buffered words may never exceed the buffer, so every response has a slot.
   assign inflight = {1'b0, out_cnt_q} + {1'b0, occ};
   assign credit   = inflight < (CW + 1)'(BUF_DEPTH);

   assign IMemReq  = resetl && credit && !Redirect;
   assign IMemAddr = fetch_pc_q;
   assign req_fire = IMemReq && IMemReady;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_ok   = IMemRspValid && (out_cnt_q != '0);
   assign rsp_drop = rsp_ok && (state_q == StFlush);
   assign rsp_keep = rsp_ok && !rsp_drop;

   // Next values of the outstanding and to-be-dropped counters.
   always_comb begin
      out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_ok);
      drop_cnt_d = drop_cnt_q;
      if (Redirect) begin
         // Everything still outstanding after this cycle belongs to the abandoned path.
         drop_cnt_d = out_cnt_d;
      end else if (rsp_drop) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
      end
   end

   // Fetch/response PCs and the two counters.
   always_ff @(posedge CLK) begin
      if (!resetl) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         if (Redirect) begin
            fetch_pc_q <= redirect_pc;
            rsp_pc_q   <= redirect_pc;
         end else begin
            if (req_fire) begin
               fetch_pc_q <= fetch_pc_q + ADDR_W'(INST_BYTES);
            end
            if (rsp_keep) begin
               rsp_pc_q <= rsp_pc_q + ADDR_W'(INST_BYTES);
            end
         end
      end
   end

   // FLUSH lasts exactly as long as there are stale responses left to discard.
   always_ff @(posedge CLK) begin
      if (!resetl) begin
         state_q <= StFetch;
      end else begin
         unique case (state_q)
            StFetch: if (drop_cnt_d != '0) state_q <= StFlush;
            StFlush: if (drop_cnt_d == '0) state_q <= StFetch;
         endcase
      end
   end

   fetch_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (BW)
   ) u_buf (
      .clk_i       (CLK),
      .resetl_i    (resetl),
      .push_i      (rsp_keep),
      .push_data_i ({rsp_pc_q, IMemRspData}),
      .pop_i       (InstReady && !Redirect),
      .flush_i     (Redirect),
      .valid_o     (buf_valid),
      .head_o      (buf_head),
      .occ_o       (occ)
   );

   assign InstValid = buf_valid;
   assign Inst      = buf_head[INST_W-1:0];
   assign InstPC    = buf_head[INST_W +: ADDR_W];

`ifndef SYNTHESIS
   // Memory must not answer a request that was never made.
   rsp_without_req: assert property (@(posedge CLK) disable iff (!resetl)
      IMemRspValid |-> (out_cnt_q != '0))
      else $error("fetch_unit: IMemRspValid with no outstanding request");

   // Credit keeps the stale-response count bounded by what is outstanding.
   drop_bounded: assert property (@(posedge CLK) disable iff (!resetl)
      drop_cnt_q <= out_cnt_q)
      else $error("fetch_unit: drop count exceeds outstanding count");
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency, scoreboard of expected
// {PC, instruction} pairs built from the addresses the unit requests, and directed scenarios.
module tb_fetch_unit;

   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned INST_W    = 32;
   localparam int unsigned BUF_DEPTH = 2;

   logic              CLK = 1'b0;
   logic              resetl;
   logic              IMemReq;
   logic [ADDR_W-1:0] IMemAddr;
   logic              IMemReady;
   logic              IMemRspValid;
   logic [INST_W-1:0] IMemRspData;
   logic              InstValid;
   logic [INST_W-1:0] Inst;
   logic [ADDR_W-1:0] InstPC;
   logic              InstReady;
   logic              Redirect;
   logic [ADDR_W-1:0] RedirectPC;

   fetch_unit #(
      .ADDR_W    (ADDR_W),
      .INST_W    (INST_W),
      .BUF_DEPTH (BUF_DEPTH),
      .RESET_PC  (64'h0)
   ) dut (
      .CLK          (CLK),
      .resetl       (resetl),
      .IMemReq      (IMemReq),
      .IMemAddr     (IMemAddr),
      .IMemReady    (IMemReady),
      .IMemRspValid (IMemRspValid),
      .IMemRspData  (IMemRspData),
      .InstValid    (InstValid),
      .Inst         (Inst),
      .InstPC       (InstPC),
      .InstReady    (InstReady),
      .Redirect     (Redirect),
      .RedirectPC   (RedirectPC)
   );

   initial forever #5 CLK = ~CLK;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      bit                keep;
      int                ready;
   } req_t;

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } exp_t;

   req_t              pending[$];
   exp_t              exp_q[$];
   logic [ADDR_W-1:0] pop_log[$];
   int                cyc = 0;
   int                lat_min = 1;
   int                lat_max = 1;
   int                last_ready = 0;
   int                fire_cnt = 0;
   int                pop_cnt = 0;
   int                checks = 0;
   int                passed = 0;
   bit                rsp_now;
   bit                rsp_keep;
   logic [ADDR_W-1:0] rsp_addr;
   logic [ADDR_W-1:0] efpc = '0;

   function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic bit rsp_due();
      return resetl && (pending.size() > 0) && (pending[0].ready <= cyc);
   endfunction

   // Memory side: return the oldest request once its latency has elapsed.
   task automatic drive_rsp();
      req_t r;
      rsp_now = rsp_due();
      if (rsp_now) begin
         r = pending.pop_front();
         IMemRspValid = 1'b1;
         IMemRspData  = mem_word(r.addr);
         rsp_keep     = r.keep;
         rsp_addr     = r.addr;
      end else begin
         IMemRspValid = 1'b0;
         IMemRspData  = 32'hDEAD_BEEF;
         rsp_keep     = 1'b0;
      end
   endtask

   // Mid-cycle view of what the coming edge will do; updates the reference model.
   task automatic observe();
      int   outs;
      bit   exp_req;
      req_t r;
      exp_t e;
      if (!resetl) begin
         checks++;
         if (IMemReq !== 1'b0) $display("FAIL req_in_reset: IMemReq=%b want 0", IMemReq);
         else passed++;
         pending.delete();
         exp_q.delete();
         efpc       = '0;
         last_ready = cyc;
         return;
      end
      outs    = pending.size() + (rsp_now ? 1 : 0);
      exp_req = !Redirect && ((outs + exp_q.size()) < BUF_DEPTH);
      checks++;
      if (IMemReq !== exp_req) $display("FAIL credit: IMemReq=%b want %b (cyc %0d)",
                                        IMemReq, exp_req, cyc);
      else passed++;
      if (IMemReq === 1'b1 && IMemReady) begin
         checks++;
         if (IMemAddr !== efpc) $display("FAIL fetch_addr: IMemAddr=%h want %h", IMemAddr, efpc);
         else passed++;
         r.addr  = IMemAddr;
         r.keep  = 1'b1;
         r.ready = cyc + int'($urandom_range(lat_min, lat_max));
         if (r.ready < last_ready) r.ready = last_ready;
         last_ready = r.ready;
         pending.push_back(r);
         efpc = efpc + 64'd4;
         fire_cnt++;
      end
      checks++;
      if (InstValid !== (exp_q.size() != 0)) $display("FAIL inst_valid: InstValid=%b want %b",
                                                      InstValid, exp_q.size() != 0);
      else passed++;
      if (Redirect) begin
         exp_q.delete();
         foreach (pending[i]) pending[i].keep = 1'b0;
         efpc = {RedirectPC[ADDR_W-1:2], 2'b00};
      end else begin
         if (InstValid === 1'b1 && InstReady) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL extra_inst: got PC %h with nothing expected", InstPC);
            end else begin
               e = exp_q.pop_front();
               if ({InstPC, Inst} !== {e.pc, e.inst})
                  $display("FAIL inst_data: got %h/%h want %h/%h", InstPC, Inst, e.pc, e.inst);
               else passed++;
               pop_log.push_back(InstPC);
               pop_cnt++;
            end
         end
         if (rsp_now && rsp_keep) begin
            e.pc   = rsp_addr;
            e.inst = mem_word(rsp_addr);
            exp_q.push_back(e);
         end
      end
   endtask

   // One clock: called at a falling edge with inputs already set for the next rising edge.
   task automatic tick();
      drive_rsp();
      #1;
      observe();
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
   endtask

   task automatic apply_reset();
      resetl    = 1'b0;
      Redirect  = 1'b0;
      InstReady = 1'b1;
      IMemReady = 1'b1;
      tick();
      tick();
      resetl = 1'b1;
      pop_log.delete();
      fire_cnt = 0;
      pop_cnt  = 0;
   endtask

   task automatic test_reset();
      resetl     = 1'b0;
      Redirect   = 1'b0;
      RedirectPC = '0;
      InstReady  = 1'b1;
      IMemReady  = 1'b1;
      tick();
      tick();
      checks++;
      if (InstValid !== 1'b0) $display("FAIL rst_valid: InstValid=%b want 0", InstValid);
      else passed++;
      checks++;
      if (Inst !== 32'h0) $display("FAIL rst_inst: Inst=%h want 0", Inst);
      else passed++;
      checks++;
      if (InstPC !== 64'h0) $display("FAIL rst_instpc: InstPC=%h want 0", InstPC);
      else passed++;
      checks++;
      if (IMemAddr !== 64'h0) $display("FAIL rst_addr: IMemAddr=%h want 0", IMemAddr);
      else passed++;
      checks++;
      if (IMemReq !== 1'b0) $display("FAIL rst_req: IMemReq=%b want 0", IMemReq);
      else passed++;
   endtask

   task automatic test_stream();
      int first = -1;
      logic [ADDR_W-1:0] want;
      lat_min = 1;
      lat_max = 1;
      apply_reset();
      for (int k = 1; k <= 12; k++) begin
         if (InstValid === 1'b1 && first < 0) first = k;
         tick();
      end
      checks++;
      if (first != 3) $display("FAIL first_valid_cycle: got %0d want 3", first);
      else passed++;
      checks++;
      if (pop_log.size() < 6) begin
         $display("FAIL stream_count: got %0d want >=6", pop_log.size());
      end else begin
         int bad = 0;
         for (int i = 0; i < 6; i++) begin
            want = 64'(4 * i);
            if (pop_log[i] !== want) bad++;
         end
         if (bad != 0) $display("FAIL stream_order: got %0d bad PCs want 0", bad);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      logic [ADDR_W-1:0] want;
      lat_min = 1;
      lat_max = 1;
      apply_reset();
      InstReady = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      checks++;
      if (fire_cnt != 2) $display("FAIL stall_fires: got %0d want 2", fire_cnt);
      else passed++;
      checks++;
      if (IMemReq !== 1'b0) $display("FAIL stall_req: IMemReq=%b want 0", IMemReq);
      else passed++;
      InstReady = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      checks++;
      if (pop_cnt < 12) $display("FAIL resume_count: got %0d want >=12", pop_cnt);
      else passed++;
      for (int i = 0; i < pop_log.size(); i++) begin
         want = 64'(4 * i);
         if (pop_log[i] !== want) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL resume_order: got %0d bad PCs want 0", bad);
      else passed++;
   endtask

   task automatic test_redirect_drop();
      lat_min = 3;
      lat_max = 3;
      apply_reset();
      for (int i = 0; i < 20 && !(pending.size() == 2 && pending[0].ready > cyc); i++) tick();
      checks++;
      if (!(pending.size() == 2 && pending[0].ready > cyc))
         $display("FAIL drop_setup: outstanding=%0d want 2", pending.size());
      else passed++;
      pop_log.delete();
      Redirect   = 1'b1;
      RedirectPC = 64'h100;
      tick();
      Redirect = 1'b0;
      for (int i = 0; i < 30 && pop_log.size() < 2; i++) tick();
      checks++;
      if (pop_log.size() < 2) begin
         $display("FAIL drop_timeout: got %0d insts want 2", pop_log.size());
      end else if (pop_log[0] !== 64'h100 || pop_log[1] !== 64'h104) begin
         $display("FAIL drop_pcs: got %h,%h want 100,104", pop_log[0], pop_log[1]);
      end else passed++;
   endtask

   task automatic test_redirect_collide();
      lat_min = 1;
      lat_max = 1;
      apply_reset();
      for (int i = 0; i < 20 && !(rsp_due() && InstValid === 1'b1); i++) tick();
      checks++;
      if (!(rsp_due() && InstValid === 1'b1)) $display("FAIL collide_setup: got 0 want 1");
      else passed++;
      pop_log.delete();
      Redirect   = 1'b1;
      RedirectPC = 64'h203;
      tick();
      Redirect = 1'b0;
      checks++;
      if (InstValid !== 1'b0) $display("FAIL collide_valid: InstValid=%b want 0", InstValid);
      else passed++;
      checks++;
      if (IMemAddr !== 64'h200) $display("FAIL collide_addr: IMemAddr=%h want 200", IMemAddr);
      else passed++;
      for (int i = 0; i < 20 && pop_log.size() < 1; i++) tick();
      checks++;
      if (pop_log.size() < 1) $display("FAIL collide_timeout: got 0 insts want 1");
      else if (pop_log[0] !== 64'h200) $display("FAIL collide_pc: got %h want 200", pop_log[0]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int stale = 0;
      lat_min = 3;
      lat_max = 3;
      apply_reset();
      for (int i = 0; i < 20 && !(pending.size() == 2 && pending[0].ready > cyc); i++) tick();
      pop_log.delete();
      Redirect   = 1'b1;
      RedirectPC = 64'h40;
      tick();
      RedirectPC = 64'h80;
      tick();
      Redirect = 1'b0;
      for (int i = 0; i < 40 && pop_log.size() < 4; i++) tick();
      checks++;
      if (pop_log.size() < 4) $display("FAIL b2b_timeout: got %0d insts want 4", pop_log.size());
      else if (pop_log[0] !== 64'h80) $display("FAIL b2b_first: got %h want 80", pop_log[0]);
      else passed++;
      foreach (pop_log[i]) if (pop_log[i] >= 64'h40 && pop_log[i] < 64'h80) stale++;
      checks++;
      if (stale != 0) $display("FAIL b2b_stale: got %0d stale insts want 0", stale);
      else passed++;
   endtask

   task automatic test_reset_midstream();
      lat_min = 2;
      lat_max = 2;
      apply_reset();
      InstReady = 1'b0;
      for (int i = 0; i < 20 && !(exp_q.size() == 1 && pending.size() == 1); i++) tick();
      checks++;
      if (!(exp_q.size() == 1 && pending.size() == 1))
         $display("FAIL mid_setup: buffered=%0d outstanding=%0d want 1,1",
                  exp_q.size(), pending.size());
      else passed++;
      resetl = 1'b0;
      tick();
      checks++;
      if (InstValid !== 1'b0) $display("FAIL mid_valid: InstValid=%b want 0", InstValid);
      else passed++;
      checks++;
      if (IMemAddr !== 64'h0) $display("FAIL mid_addr: IMemAddr=%h want 0", IMemAddr);
      else passed++;
      pop_log.delete();
      resetl    = 1'b1;
      InstReady = 1'b1;
      #1;
      checks++;
      if (IMemReq !== 1'b1) $display("FAIL mid_credit: IMemReq=%b want 1", IMemReq);
      else passed++;
      for (int i = 0; i < 30 && pop_log.size() < 2; i++) tick();
      checks++;
      if (pop_log.size() < 2) $display("FAIL mid_timeout: got %0d insts want 2", pop_log.size());
      else if (pop_log[0] !== 64'h0 || pop_log[1] !== 64'h4)
         $display("FAIL mid_restart: got %h,%h want 0,4", pop_log[0], pop_log[1]);
      else passed++;
   endtask

   task automatic test_random();
      lat_min = 1;
      lat_max = 3;
      apply_reset();
      for (int k = 0; k < 400; k++) begin
         IMemReady  = ($urandom_range(0, 3) != 0);
         InstReady  = ($urandom_range(0, 9) < 7);
         Redirect   = ($urandom_range(0, 19) == 0);
         RedirectPC = 64'($urandom_range(0, 4095));
         tick();
      end
      Redirect = 1'b0;
      checks++;
      if (pop_cnt < 20) $display("FAIL random_progress: got %0d insts want >=20", pop_cnt);
      else passed++;
   endtask

   initial begin
      IMemRspValid = 1'b0;
      IMemRspData  = '0;
      @(negedge CLK);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_redirect_collide();
      test_back_to_back();
      test_reset_midstream();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
